// File: rtl/axi_slave_cmd_queue.sv
// AXI address-channel command queue: valid/ready on both sides, first-word-fall-through
// output, occupancy count, registered almost-full flag, high-water mark and synchronous flush.
module axi_slave_cmd_queue #(
    parameter int unsigned IDW          = 5,
    parameter int unsigned CTXW         = 9,
    parameter int unsigned ADDRW        = 64,
    parameter int unsigned DEPTH_LOG2   = 4,
    parameter int unsigned AFULL_MARGIN = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [IDW-1:0]        s_id,
    input  logic [ADDRW-1:0]      s_addr,
    input  logic [7:0]            s_len,
    input  logic [2:0]            s_size,
    input  logic [1:0]            s_burst,
    input  logic [CTXW-1:0]       s_user,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [IDW-1:0]        m_id,
    output logic [ADDRW-1:0]      m_addr,
    output logic [7:0]            m_len,
    output logic [2:0]            m_size,
    output logic [1:0]            m_burst,
    output logic [CTXW-1:0]       m_user,
    output logic                  almost_full,
    output logic [DEPTH_LOG2:0]   count,
    output logic [DEPTH_LOG2:0]   hwm,
    input  logic                  flush,
    input  logic                  clear_hwm
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned W     = IDW + ADDRW + 8 + 3 + 2 + CTXW;
    localparam int unsigned CNTW  = DEPTH_LOG2 + 1;

    localparam logic [CNTW-1:0] CntFull  = CNTW'(DEPTH);
    localparam logic [CNTW-1:0] CntAfull = CNTW'(DEPTH - AFULL_MARGIN);

    // Reject parameter sets the pointer/count arithmetic cannot support.
    if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 8) begin : g_bad_depth
        $error("axi_slave_cmd_queue: DEPTH_LOG2 must be in 1..8");
    end
    if (ADDRW < 1 || ADDRW > 64) begin : g_bad_addrw
        $error("axi_slave_cmd_queue: ADDRW must be in 1..64");
    end
    if (AFULL_MARGIN < 1 || AFULL_MARGIN > DEPTH - 1) begin : g_bad_margin
        $error("axi_slave_cmd_queue: AFULL_MARGIN must be in 1..DEPTH-1");
    end

    logic [W-1:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0]   wptr_q, wptr_d;
    logic [DEPTH_LOG2-1:0]   rptr_q, rptr_d;
    logic [CNTW-1:0]         count_q, count_d;
    logic [CNTW-1:0]         hwm_q, hwm_d;
    logic                    afull_q, afull_d;
    logic                    rdy_q;
    logic                    push, pop;
    logic [W-1:0]            head;

    // Handshake qualifiers; flush blocks both sides in the same cycle.
    always_comb begin
        s_ready = rdy_q & (count_q != CntFull) & ~flush;
        m_valid = (count_q != '0) & ~flush;
        push    = s_valid & s_ready;
        pop     = m_valid & m_ready;
    end

    // Next-state for pointers, occupancy, almost-full and high-water mark.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + 1'b1;
            if (pop)  rptr_d = rptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
        afull_d = (count_d >= CntAfull);
        if (clear_hwm)            hwm_d = count_d;
        else if (count_d > hwm_q) hwm_d = count_d;
        else                      hwm_d = hwm_q;
    end

    // Control state; rdy_q holds s_ready low for one edge after reset release.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            hwm_q   <= '0;
            afull_q <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            hwm_q   <= hwm_d;
            afull_q <= afull_d;
            rdy_q   <= 1'b1;
        end
    end

    // Entry storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= {s_id, s_addr, s_len, s_size, s_burst, s_user};
    end

    // Head entry drives the outputs directly (first-word-fall-through).
    always_comb begin
        head = mem_q[rptr_q];
        {m_id, m_addr, m_len, m_size, m_burst, m_user} = head;
        almost_full = afull_q;
        count       = count_q;
        hwm         = hwm_q;
    end

endmodule

// File: tb/tb_axi_slave_cmd_queue.sv
// Bench for axi_slave_cmd_queue: queue-based reference model checked every cycle on the
// falling edge, plus directed scenarios with literal expectations.
module tb_axi_slave_cmd_queue;

    localparam int IDW = 5, CTXW = 9, ADDRW = 64, DL2 = 4, MARGIN = 2;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic [IDW-1:0]   id;
        logic [ADDRW-1:0] addr;
        logic [7:0]       len;
        logic [2:0]       size;
        logic [1:0]       burst;
        logic [CTXW-1:0]  user;
    } cmd_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic s_valid = 1'b0, m_ready = 1'b0, flush = 1'b0, clear_hwm = 1'b0;
    logic s_ready, m_valid, almost_full;
    logic [IDW-1:0] s_id = '0, m_id;
    logic [ADDRW-1:0] s_addr = '0, m_addr;
    logic [7:0] s_len = '0, m_len;
    logic [2:0] s_size = '0, m_size;
    logic [1:0] s_burst = '0, m_burst;
    logic [CTXW-1:0] s_user = '0, m_user;
    logic [DL2:0] count, hwm;

    int vectors = 0;
    int miscompares = 0;

    axi_slave_cmd_queue #(
        .IDW(IDW), .CTXW(CTXW), .ADDRW(ADDRW), .DEPTH_LOG2(DL2), .AFULL_MARGIN(MARGIN)
    ) dut (
        .clk(clk), .resetn(resetn),
        .s_valid(s_valid), .s_ready(s_ready), .s_id(s_id), .s_addr(s_addr), .s_len(s_len),
        .s_size(s_size), .s_burst(s_burst), .s_user(s_user),
        .m_valid(m_valid), .m_ready(m_ready), .m_id(m_id), .m_addr(m_addr), .m_len(m_len),
        .m_size(m_size), .m_burst(m_burst), .m_user(m_user),
        .almost_full(almost_full), .count(count), .hwm(hwm),
        .flush(flush), .clear_hwm(clear_hwm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of commands plus scalar statistics.
    cmd_t mq[$];
    int   m_hwm = 0;
    bit   m_rdy = 0;

    always @(negedge clk) begin
        bit   e_sready, e_mvalid, do_push, do_pop;
        cmd_t in_cmd, head;
        if (!resetn) begin
            mq.delete();
            m_hwm = 0;
            m_rdy = 0;
            chk("rst_s_ready", 64'(s_ready), 64'd0);
            chk("rst_m_valid", 64'(m_valid), 64'd0);
            chk("rst_count", 64'(count), 64'd0);
        end else begin
            e_sready = m_rdy && (mq.size() < DEPTH) && !flush;
            e_mvalid = (mq.size() > 0) && !flush;
            chk("s_ready", 64'(s_ready), 64'(e_sready));
            chk("m_valid", 64'(m_valid), 64'(e_mvalid));
            chk("count", 64'(count), 64'(mq.size()));
            chk("hwm", 64'(hwm), 64'(m_hwm));
            chk("almost_full", 64'(almost_full), 64'(mq.size() >= DEPTH - MARGIN));
            if (e_mvalid) begin
                head = mq[0];
                chk("head", 64'({m_id, m_len, m_size, m_burst, m_user}),
                    64'({head.id, head.len, head.size, head.burst, head.user}));
                chk("head_addr", m_addr, head.addr);
            end
            do_push = s_valid && e_sready;
            do_pop  = m_ready && e_mvalid;
            in_cmd  = '{id: s_id, addr: s_addr, len: s_len, size: s_size, burst: s_burst,
                        user: s_user};
            if (flush) mq.delete();
            else begin
                if (do_pop)  void'(mq.pop_front());
                if (do_push) mq.push_back(in_cmd);
            end
            if (clear_hwm) m_hwm = mq.size();
            else if (mq.size() > m_hwm) m_hwm = mq.size();
            m_rdy = 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int n);
        s_id    = IDW'(n);
        s_addr  = 64'h0000_2000_0000_0000 + 64'(n) * 64;
        s_len   = 8'(n * 3);
        s_size  = 3'(n);
        s_burst = 2'(n % 3);
        s_user  = CTXW'(n * 7);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("lit_rst_s_ready", 64'(s_ready), 64'd0);
        resetn = 1'b1;
        #1;
        chk("lit_ready_delay", 64'(s_ready), 64'd0);
        step();
        chk("lit_ready_after_edge", 64'(s_ready), 64'd1);

        // First push into an empty queue appears on the next cycle.
        s_id = 5'd3; s_addr = 64'h0000_1000_0000_0040; s_len = 8'd7;
        s_size = 3'd2; s_burst = 2'd1; s_user = 9'h1a5;
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        chk("lit_first_m_valid", 64'(m_valid), 64'd1);
        chk("lit_first_m_id", 64'(m_id), 64'd3);
        chk("lit_first_m_addr", m_addr, 64'h0000_1000_0000_0040);
        chk("lit_first_m_len", 64'(m_len), 64'd7);
        chk("lit_first_count", 64'(count), 64'd1);
        chk("lit_first_hwm", 64'(hwm), 64'd1);

        // Fill to 16 with the consumer stalled.
        for (int i = 1; i < 16; i++) begin
            set_cmd(i);
            s_valid = 1'b1;
            step();
            if (i == 12) chk("lit_afull_at13", 64'(almost_full), 64'd0);
            if (i == 13) chk("lit_afull_at14", 64'(almost_full), 64'd1);
        end
        // A 17th command is held off.
        set_cmd(99);
        repeat (3) step();
        chk("lit_full_s_ready", 64'(s_ready), 64'd0);
        chk("lit_full_count", 64'(count), 64'd16);
        chk("lit_full_hwm", 64'(hwm), 64'd16);

        // Full queue with both sides active: pop only.
        m_ready = 1'b1;
        step();
        chk("lit_pop_only_count", 64'(count), 64'd15);
        chk("lit_pop_only_s_ready", 64'(s_ready), 64'd1);

        // Streaming across pointer wrap keeps occupancy constant.
        for (int i = 0; i < 40; i++) begin
            set_cmd(100 + i);
            step();
        end
        chk("lit_stream_count", 64'(count), 64'd15);

        // Drain, then restart the high-water mark.
        s_valid = 1'b0;
        repeat (16) step();
        m_ready = 1'b0;
        chk("lit_drained", 64'(count), 64'd0);
        clear_hwm = 1'b1;
        step();
        clear_hwm = 1'b0;
        chk("lit_hwm_cleared", 64'(hwm), 64'd0);

        // Queue 8 entries, then flush for one cycle while offering another push.
        for (int i = 0; i < 8; i++) begin
            set_cmd(200 + i);
            s_valid = 1'b1;
            step();
        end
        set_cmd(250);
        flush = 1'b1;
        #1;
        chk("lit_flush_m_valid", 64'(m_valid), 64'd0);
        chk("lit_flush_s_ready", 64'(s_ready), 64'd0);
        step();
        flush = 1'b0;
        s_valid = 1'b0;
        chk("lit_post_flush_count", 64'(count), 64'd0);
        chk("lit_post_flush_afull", 64'(almost_full), 64'd0);
        chk("lit_post_flush_hwm", 64'(hwm), 64'd8);
        s_id = 5'd5;
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        chk("lit_after_flush_id", 64'(m_id), 64'd5);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;

        // Peak of 12, drain to 4, then clear the high-water mark.
        clear_hwm = 1'b1;
        step();
        clear_hwm = 1'b0;
        for (int i = 0; i < 12; i++) begin
            set_cmd(300 + i);
            s_valid = 1'b1;
            step();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (8) step();
        m_ready = 1'b0;
        chk("lit_peak_hwm", 64'(hwm), 64'd12);
        clear_hwm = 1'b1;
        step();
        clear_hwm = 1'b0;
        chk("lit_clear_hwm", 64'(hwm), 64'd4);

        // Asynchronous reset mid-burst at count 9.
        for (int i = 0; i < 5; i++) begin
            set_cmd(400 + i);
            s_valid = 1'b1;
            step();
        end
        chk("lit_pre_reset_count", 64'(count), 64'd9);
        #2;
        resetn = 1'b0;
        #1;
        chk("lit_async_count", 64'(count), 64'd0);
        chk("lit_async_hwm", 64'(hwm), 64'd0);
        chk("lit_async_afull", 64'(almost_full), 64'd0);
        chk("lit_async_m_valid", 64'(m_valid), 64'd0);
        chk("lit_async_s_ready", 64'(s_ready), 64'd0);
        repeat (2) step();
        chk("lit_held_s_ready", 64'(s_ready), 64'd0);
        s_valid = 1'b0;
        resetn = 1'b1;
        #1;
        chk("lit_release_s_ready", 64'(s_ready), 64'd0);
        step();
        chk("lit_release_edge_s_ready", 64'(s_ready), 64'd1);
        set_cmd(500);
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        chk("lit_post_reset_count", 64'(count), 64'd1);
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
